// File: rtl/parity_frame_receiver_pkg.sv
// Shared types and helpers for the odd-parity serial frame receiver.
// Imported by the interface and the receiver top.
package parity_frame_receiver_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // A one-bit frame still needs a one-bit counter, so clamp the log at 1.
   function automatic int counter_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/parity_frame_receiver_if.sv
// Bit-level input side, word-level output side and status signals of the receiver.
// The receiver uses the slave modport; the line sampler/consumer side uses master.
interface parity_frame_receiver_if #(
   parameter int width       = 8,
   parameter int count_width = 8
);
   logic                   i_start;
   logic                   i_valid;
   logic                   i_bit;
   logic                   i_ready;
   logic                   i_clear;
   logic                   o_valid;
   logic [width-1:0]       o_data;
   logic                   o_error;
   logic [count_width-1:0] o_error_count;
   logic                   o_framing;
   logic                   o_overrun;

   modport slave (
      input  i_start, i_valid, i_bit, i_ready, i_clear,
      output o_valid, o_data, o_error, o_error_count, o_framing, o_overrun
   );

   modport master (
      output i_start, i_valid, i_bit, i_ready, i_clear,
      input  o_valid, o_data, o_error, o_error_count, o_framing, o_overrun
   );
endinterface

// File: rtl/parity_frame_receiver.sv
// Collects width data bits (LSB first) plus an odd-parity bit, then holds the word
// on a valid/ready handshake while tracking parity errors and sticky framing/overrun.
module parity_frame_receiver
   import parity_frame_receiver_pkg::*;
#(
   parameter int width       = 8,
   parameter int count_width = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   parity_frame_receiver_if.slave  bus
);

   localparam int cnt_w = counter_width(width);

   state_t             state;
   logic [width-1:0]   shift_reg;
   logic [cnt_w-1:0]   bit_cnt;
   logic               parity_acc;
   logic               frame_bad;

   assign frame_bad = ~(parity_acc ^ bus.i_bit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         shift_reg         <= '0;
         bit_cnt           <= '0;
         parity_acc        <= 1'b0;
         bus.o_valid       <= 1'b0;
         bus.o_data        <= '0;
         bus.o_error       <= 1'b0;
         bus.o_error_count <= '0;
         bus.o_framing     <= 1'b0;
         bus.o_overrun     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_start) begin
                  state      <= SHIFT;
                  bit_cnt    <= '0;
                  parity_acc <= 1'b0;
               end
            end

            SHIFT, PARITY: begin
               if (bus.i_start) begin
                  state         <= SHIFT;
                  bit_cnt       <= '0;
                  parity_acc    <= 1'b0;
                  bus.o_framing <= 1'b1;
               end else if (bus.i_valid && state == SHIFT) begin
                  shift_reg[bit_cnt] <= bus.i_bit;
                  parity_acc         <= parity_acc ^ bus.i_bit;
                  bit_cnt            <= bit_cnt + cnt_w'(1);
                  if (bit_cnt == cnt_w'(width - 1))
                     state <= PARITY;
               end else if (bus.i_valid) begin
                  bus.o_data  <= shift_reg;
                  bus.o_error <= frame_bad;
                  bus.o_valid <= 1'b1;
                  state       <= HOLD;
                  if (frame_bad && !(&bus.o_error_count))
                     bus.o_error_count <= bus.o_error_count + count_width'(1);
               end
            end

            HOLD: begin
               if (bus.i_ready) begin
                  bus.o_valid <= 1'b0;
                  if (bus.i_start) begin
                     state      <= SHIFT;
                     bit_cnt    <= '0;
                     parity_acc <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (bus.i_start) begin
                  bus.o_overrun <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase

         // Placed last so a host clear beats any same-cycle increment or flag set.
         if (bus.i_clear) begin
            bus.o_error_count <= '0;
            bus.o_framing     <= 1'b0;
            bus.o_overrun     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver: hand-computed frames, backpressure,
// restart, counter saturation with clear, and asynchronous reset mid-frame.
module tb_parity_frame_receiver;

   logic clk;
   logic rst;
   int   vecCount;
   int   missCount;

   parity_frame_receiver_if #(.width(8), .count_width(8)) bus ();

   parity_frame_receiver #(.width(8), .count_width(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic sendBits(input logic [7:0] data, input logic parity, input logic clr);
      for (int i = 0; i < 8; i++) begin
         bus.i_valid = 1'b1;
         bus.i_bit   = data[i];
         tick();
      end
      bus.i_valid = 1'b1;
      bus.i_bit   = parity;
      bus.i_clear = clr;
      tick();
      bus.i_valid = 1'b0;
      bus.i_bit   = 1'b0;
      bus.i_clear = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic clr);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      sendBits(data, parity, clr);
   endtask

   task automatic acceptWord();
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
   endtask

   initial begin
      vecCount    = 0;
      missCount   = 0;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_bit   = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_clear = 1'b0;
      rst         = 1'b1;
      repeat (2) tick();
      checkOutput("rst_valid", 32'(bus.o_valid), 0);
      checkOutput("rst_data", 32'(bus.o_data), 0);
      checkOutput("rst_error", 32'(bus.o_error), 0);
      checkOutput("rst_count", 32'(bus.o_error_count), 0);
      checkOutput("rst_flags", 32'({bus.o_framing, bus.o_overrun}), 0);
      rst = 1'b0;
      tick();

      // Good frame: 0xA5 has four ones, parity 1 makes it odd.
      applyStimulus(8'hA5, 1'b1, 1'b0);
      checkOutput("a5_valid", 32'(bus.o_valid), 1);
      checkOutput("a5_data", 32'(bus.o_data), 32'hA5);
      checkOutput("a5_error", 32'(bus.o_error), 0);
      checkOutput("a5_count", 32'(bus.o_error_count), 0);
      acceptWord();
      checkOutput("a5_drop", 32'(bus.o_valid), 0);

      applyStimulus(8'hA5, 1'b0, 1'b0);
      checkOutput("bad_error", 32'(bus.o_error), 1);
      checkOutput("bad_count", 32'(bus.o_error_count), 1);
      acceptWord();

      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("zero_data", 32'(bus.o_data), 0);
      checkOutput("zero_error", 32'(bus.o_error), 0);
      checkOutput("zero_count", 32'(bus.o_error_count), 1);

      // Not accepted: stall on a pending 0x00 is not distinguishable from reset, so use 0x5A.
      acceptWord();
      applyStimulus(8'h5A, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         bus.i_start = (k == 2);
         bus.i_valid = 1'b1;
         bus.i_bit   = 1'b1;
         tick();
         checkOutput("stall_valid", 32'(bus.o_valid), 1);
         checkOutput("stall_data", 32'(bus.o_data), 32'h5A);
      end
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      checkOutput("overrun_set", 32'(bus.o_overrun), 1);

      bus.i_ready = 1'b1;
      bus.i_start = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      bus.i_start = 1'b0;
      checkOutput("b2b_drop", 32'(bus.o_valid), 0);
      sendBits(8'h3C, 1'b1, 1'b0);
      checkOutput("b2b_valid", 32'(bus.o_valid), 1);
      checkOutput("b2b_data", 32'(bus.o_data), 32'h3C);
      checkOutput("b2b_error", 32'(bus.o_error), 0);
      acceptWord();

      // Abort after three bits, then a clean 0x01 with parity 0.
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.i_valid = 1'b1;
         bus.i_bit   = 1'b1;
         tick();
      end
      bus.i_valid = 1'b0;
      checkOutput("pre_framing", 32'(bus.o_framing), 0);
      applyStimulus(8'h01, 1'b0, 1'b0);
      checkOutput("rs_framing", 32'(bus.o_framing), 1);
      checkOutput("rs_data", 32'(bus.o_data), 32'h01);
      checkOutput("rs_error", 32'(bus.o_error), 0);
      acceptWord();

      bus.i_clear = 1'b1;
      tick();
      bus.i_clear = 1'b0;
      checkOutput("clr_count", 32'(bus.o_error_count), 0);
      checkOutput("clr_flags", 32'({bus.o_framing, bus.o_overrun}), 0);

      // 257 bad frames; last one left pending.
      for (int i = 0; i < 257; i++) begin
         applyStimulus(8'hA5, 1'b0, 1'b0);
         if (i == 253) checkOutput("count_254", 32'(bus.o_error_count), 254);
         if (i == 254) checkOutput("count_255", 32'(bus.o_error_count), 255);
         if (i < 256) acceptWord();
      end
      checkOutput("sat_count", 32'(bus.o_error_count), 255);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      acceptWord();
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.i_valid = 1'b1;
         bus.i_bit   = 1'b0;
         tick();
      end
      bus.i_valid = 1'b0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      checkOutput("sat_flags", 32'({bus.o_framing, bus.o_overrun}), 32'h3);
      sendBits(8'hA5, 1'b0, 1'b1);
      checkOutput("clrw_count", 32'(bus.o_error_count), 0);
      checkOutput("clrw_flags", 32'({bus.o_framing, bus.o_overrun}), 0);
      checkOutput("clrw_error", 32'(bus.o_error), 1);
      checkOutput("clrw_valid", 32'(bus.o_valid), 1);
      acceptWord();

      // Asynchronous reset between edges while shifting.
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.i_valid = 1'b1;
         bus.i_bit   = 1'b1;
         tick();
      end
      bus.i_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_data", 32'(bus.o_data), 0);
      checkOutput("arst_error", 32'(bus.o_error), 0);
      checkOutput("arst_valid", 32'(bus.o_valid), 0);
      #2;
      rst = 1'b0;
      tick();
      applyStimulus(8'hFF, 1'b1, 1'b0);
      checkOutput("ff_valid", 32'(bus.o_valid), 1);
      checkOutput("ff_data", 32'(bus.o_data), 32'hFF);
      checkOutput("ff_error", 32'(bus.o_error), 0);
      acceptWord();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
